// File: rtl/fb_pkg.sv
// Shared defaults, FSM encoding and width helper for the framebuffer scanout reader.
package fb_pkg;

  localparam int FB_ADDR_WIDTH = 8;
  localparam int FB_DATA_WIDTH = 8;
  localparam int FB_BPP        = 2;
  localparam int FB_PPW        = FB_DATA_WIDTH / FB_BPP;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Four-entry word FIFO between the RAM read port and the pixel unpacker.
module fb_word_fifo
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [2:0]            count,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [4];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 3'd0);

endmodule

// File: rtl/fb_scanout_reader.sv
// Walks one frame of packed words out of the framebuffer RAM and streams
// the unpacked pixels with line/frame markers under valid/ready flow control.
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH     = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = FB_DATA_WIDTH,
  parameter int BPP            = FB_BPP,
  parameter int WORDS_PER_LINE = 2,
  parameter int LINES          = 2,
  parameter int BASE_ADDR      = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [BPP-1:0]        pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sol,
  output logic                  pix_eol,
  output logic                  pix_eof
);

  localparam int PPW     = DATA_WIDTH / BPP;
  localparam int PIX_MAX = WORDS_PER_LINE * PPW;
  localparam int TOTAL   = WORDS_PER_LINE * LINES;
  localparam int PIX_W   = cnt_width(PIX_MAX);
  localparam int LINE_W  = cnt_width(LINES);
  localparam int SUB_W   = cnt_width(PPW);
  localparam int WCNT_W  = $clog2(TOTAL + 1);

  fb_state_e             state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  addr_vld_q, addr_vld_d, data_vld_q, data_vld_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  uvld_q, uvld_d;
  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0]     line_q, line_d;

  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [2:0]            fifo_count;
  logic [2:0]            outstanding;
  logic                  credit_ok, fire, last_sub, last_pix, last_line;
  logic                  need_word, bypass, load;

  fb_word_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (rd_data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // A read is outstanding while its address sits in rd_addr and again while
  // its word sits on rd_data, so up to two reads overlap for full throughput.
  assign outstanding = {2'b00, addr_vld_q} + {2'b00, data_vld_q};
  assign credit_ok   = ({1'b0, fifo_count} + {1'b0, outstanding}) < 4'd4;
  assign data_vld_d  = addr_vld_q;

  assign fire      = uvld_q & pix_ready;
  assign last_sub  = (sub_q == SUB_W'(PPW - 1));
  assign last_pix  = (pix_cnt_q == PIX_W'(PIX_MAX - 1));
  assign last_line = (line_q == LINE_W'(LINES - 1));
  assign need_word = !uvld_q | (fire & last_sub);
  assign bypass    = need_word & fifo_empty & data_vld_q;
  assign fifo_pop  = need_word & !fifo_empty;
  assign fifo_push = data_vld_q & !bypass;
  assign load      = bypass | fifo_pop;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_addr_d  = rd_addr_q;
    addr_vld_d = 1'b0;
    wcnt_d     = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_addr_d  = ADDR_WIDTH'(BASE_ADDR);
          addr_vld_d = 1'b1;
          wcnt_d     = WCNT_W'(1);
          busy_d     = 1'b1;
          state_d    = (TOTAL == 1) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (credit_ok) begin
          rd_addr_d  = rd_addr_q + ADDR_WIDTH'(1);
          addr_vld_d = 1'b1;
          wcnt_d     = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(TOTAL - 1)) state_d = ST_DRAIN;
        end
      end
      default: ;
    endcase
    if (state_q != ST_IDLE && fire && last_pix && last_line) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    uvld_d    = uvld_q;
    word_d    = word_q;
    sub_d     = sub_q;
    pix_cnt_d = pix_cnt_q;
    line_d    = line_q;
    if (load) begin
      uvld_d = 1'b1;
      word_d = fifo_empty ? rd_data : fifo_rdata;
      sub_d  = '0;
    end else if (fire) begin
      uvld_d = !last_sub;
      word_d = word_q >> BPP;
      sub_d  = last_sub ? '0 : sub_q + SUB_W'(1);
    end
    if (fire) begin
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + PIX_W'(1);
      if (last_pix) line_d = last_line ? '0 : line_q + LINE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_addr_q  <= '0;
      addr_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      wcnt_q     <= '0;
      word_q     <= '0;
      uvld_q     <= 1'b0;
      sub_q      <= '0;
      pix_cnt_q  <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_addr_q  <= rd_addr_d;
      addr_vld_q <= addr_vld_d;
      data_vld_q <= data_vld_d;
      wcnt_q     <= wcnt_d;
      word_q     <= word_d;
      uvld_q     <= uvld_d;
      sub_q      <= sub_d;
      pix_cnt_q  <= pix_cnt_d;
      line_q     <= line_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign pix_valid = uvld_q;
  assign pix_data  = word_q[BPP-1:0];
  assign pix_sol   = uvld_q & (pix_cnt_q == '0);
  assign pix_eol   = uvld_q & last_pix;
  assign pix_eof   = uvld_q & last_pix & last_line;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Scoreboard bench for fb_scanout_reader: three configurations behind one
// selector, each fed by its own registered-read RAM model.
module tb_fb_scanout_reader;

  typedef struct packed {
    logic [7:0] data;
    logic       sol;
    logic       eol;
    logic       eof;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, ready;
  int   sel;
  int   checks = 0;
  int   passes = 0;
  pix_t exp_q[$];
  logic [7:0] addr_q[$];
  int   first_valid_cyc, first_hs, last_hs;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [256];

  logic       a_start, a_busy, a_done, a_valid, a_ready, a_sol, a_eol, a_eof;
  logic [7:0] a_addr, a_rdata;
  logic [1:0] a_pix;
  logic       b_start, b_busy, b_done, b_valid, b_ready, b_sol, b_eol, b_eof;
  logic [7:0] b_addr, b_rdata;
  logic [1:0] b_pix;
  logic       c_start, c_busy, c_done, c_valid, c_ready, c_sol, c_eol, c_eof;
  logic [7:0] c_addr, c_rdata;
  logic [7:0] c_pix;

  assign a_start = start && (sel == 0);
  assign b_start = start && (sel == 1);
  assign c_start = start && (sel == 2);
  assign a_ready = ready && (sel == 0);
  assign b_ready = ready && (sel == 1);
  assign c_ready = ready && (sel == 2);

  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
    c_rdata <= mem_c[c_addr];
  end

  fb_scanout_reader u_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_addr(a_addr), .rd_data(a_rdata), .pix_data(a_pix), .pix_valid(a_valid),
    .pix_ready(a_ready), .pix_sol(a_sol), .pix_eol(a_eol), .pix_eof(a_eof)
  );

  fb_scanout_reader #(.BASE_ADDR(254)) u_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_addr(b_addr), .rd_data(b_rdata), .pix_data(b_pix), .pix_valid(b_valid),
    .pix_ready(b_ready), .pix_sol(b_sol), .pix_eol(b_eol), .pix_eof(b_eof)
  );

  fb_scanout_reader #(.BPP(8), .WORDS_PER_LINE(4), .LINES(2)) u_c (
    .clk(clk), .reset_n(reset_n), .start(c_start), .busy(c_busy), .done(c_done),
    .rd_addr(c_addr), .rd_data(c_rdata), .pix_data(c_pix), .pix_valid(c_valid),
    .pix_ready(c_ready), .pix_sol(c_sol), .pix_eol(c_eol), .pix_eof(c_eof)
  );

  logic       cur_busy, cur_done, cur_valid, cur_sol, cur_eol, cur_eof;
  logic [7:0] cur_addr, cur_pix;

  always_comb begin
    cur_busy = a_busy; cur_done = a_done; cur_valid = a_valid; cur_addr = a_addr;
    cur_pix = {6'b0, a_pix}; cur_sol = a_sol; cur_eol = a_eol; cur_eof = a_eof;
    if (sel == 1) begin
      cur_busy = b_busy; cur_done = b_done; cur_valid = b_valid; cur_addr = b_addr;
      cur_pix = {6'b0, b_pix}; cur_sol = b_sol; cur_eol = b_eol; cur_eof = b_eof;
    end else if (sel == 2) begin
      cur_busy = c_busy; cur_done = c_done; cur_valid = c_valid; cur_addr = c_addr;
      cur_pix = c_pix; cur_sol = c_sol; cur_eol = c_eol; cur_eof = c_eof;
    end
  end

  function automatic logic [7:0] mem_word(input int s, input int addr);
    if (s == 1) return mem_b[addr % 256];
    if (s == 2) return mem_c[addr % 256];
    return mem_a[addr % 256];
  endfunction

  task automatic push_model(input int s);
    int base, bpp, wpl, lines, ppw, idx, line;
    logic [7:0] w;
    pix_t p;
    base  = (s == 1) ? 254 : 0;
    bpp   = (s == 2) ? 8 : 2;
    wpl   = (s == 2) ? 4 : 2;
    lines = 2;
    ppw   = 8 / bpp;
    for (int wi = 0; wi < wpl * lines; wi++) begin
      w = mem_word(s, base + wi);
      for (int k = 0; k < ppw; k++) begin
        idx    = (wi % wpl) * ppw + k;
        line   = wi / wpl;
        p.data = 8'((32'(w) >> (k * bpp)) & ((1 << bpp) - 1));
        p.sol  = (idx == 0);
        p.eol  = (idx == wpl * ppw - 1);
        p.eof  = p.eol && (line == lines - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic run_frame(input int rmode, input int ev_pix, input int ev_kind,
                           input logic [7:0] base);
    int   cyc, nhs;
    bit   stalled, saw_eof, fired;
    pix_t got, prev, exp;
    first_valid_cyc = -1; first_hs = -1; last_hs = -1;
    addr_q.delete();
    nhs = 0; stalled = 0; saw_eof = 0; fired = 0; prev = '0;
    @(negedge clk);
    start = 1'b1; ready = 1'b1; cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      ready = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      got = {cur_pix, cur_sol, cur_eol, cur_eof};
      if (cyc == 1) begin
        checks++;
        if (cur_addr !== base || cur_busy !== 1'b1)
          $display("FAIL first_read: rd_addr=%h busy=%b, expected rd_addr=%h busy=1",
                   cur_addr, cur_busy, base);
        else passes++;
        addr_q.push_back(cur_addr);
      end else if (cur_addr !== addr_q[$]) begin
        addr_q.push_back(cur_addr);
      end
      if (saw_eof) begin
        checks++;
        if (cur_done !== 1'b1 || cur_busy !== 1'b0)
          $display("FAIL done_after_eof: done=%b busy=%b, expected done=1 busy=0",
                   cur_done, cur_busy);
        else passes++;
        break;
      end
      if (stalled) begin
        checks++;
        if (cur_valid !== 1'b1 || got !== prev)
          $display("FAIL stall_hold cyc %0d: valid=%b pix=%h, expected valid=1 pix=%h",
                   cyc, cur_valid, got, prev);
        else passes++;
      end
      if (cur_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (cur_valid === 1'b1 && !fired && nhs == ev_pix) begin
        fired = 1;
        if (ev_kind == 1) begin
          start = 1'b1;
        end else if (ev_kind == 2) begin
          reset_n = 1'b0;
          #1;
          checks++;
          if ({cur_busy, cur_done, cur_valid, cur_sol, cur_eol, cur_eof} !== 6'b0 ||
              cur_addr !== 8'h00 || cur_pix !== 8'h00)
            $display("FAIL reset_mid_frame: busy/done/valid/sol/eol/eof=%b rd_addr=%h pix=%h, expected all 0",
                     {cur_busy, cur_done, cur_valid, cur_sol, cur_eol, cur_eof}, cur_addr, cur_pix);
          else passes++;
          @(negedge clk);
          reset_n = 1'b1;
          exp_q.delete();
          return;
        end
      end
      if (cur_valid === 1'b1 && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_pixel %0d: got %h, expected no more pixels", nhs, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp)
            $display("FAIL pixel %0d: got data=%h sol=%b eol=%b eof=%b, expected data=%h sol=%b eol=%b eof=%b",
                     nhs, got.data, got.sol, got.eol, got.eof, exp.data, exp.sol, exp.eol, exp.eof);
          else passes++;
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        nhs++;
        if (got.eof === 1'b1) saw_eof = 1;
      end
      stalled = (cur_valid === 1'b1) && !ready;
      prev = got;
    end
    checks++;
    if (!saw_eof || exp_q.size() != 0)
      $display("FAIL frame_end: eof_seen=%0d pixels_left=%0d, expected eof_seen=1 pixels_left=0",
               saw_eof, exp_q.size());
    else passes++;
    @(negedge clk);
    checks++;
    if (cur_done !== 1'b0)
      $display("FAIL done_pulse: done=%b one cycle later, expected 0", cur_done);
    else passes++;
  endtask

  task automatic check_latency(input string name);
    checks++;
    if (first_valid_cyc != 3)
      $display("FAIL %s_latency: first pix_valid in cycle %0d, expected 3", name, first_valid_cyc);
    else passes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (cur_busy !== 1'b0 || cur_done !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", cur_busy, cur_done);
    else passes++;
    checks++;
    if (cur_addr !== 8'h00) $display("FAIL reset_addr: rd_addr=%h, expected 00", cur_addr);
    else passes++;
    checks++;
    if ({cur_valid, cur_sol, cur_eol, cur_eof} !== 4'b0 || cur_pix !== 8'h00)
      $display("FAIL reset_stream: valid/sol/eol/eof=%b pix=%h, expected 0",
               {cur_valid, cur_sol, cur_eol, cur_eof}, cur_pix);
    else passes++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cur_busy !== 1'b0 || cur_valid !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", cur_busy, cur_valid);
    else passes++;
  endtask

  task automatic test_basic();
    int   lit [16] = '{0, 1, 2, 3, 3, 2, 1, 0, 3, 3, 3, 3, 0, 0, 0, 0};
    pix_t p;
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      p.data = 8'(lit[i]);
      p.sol  = (i == 0) || (i == 8);
      p.eol  = (i == 7) || (i == 15);
      p.eof  = (i == 15);
      exp_q.push_back(p);
    end
    run_frame(0, -1, 0, 8'h00);
    check_latency("basic");
    checks++;
    if (last_hs - first_hs != 15)
      $display("FAIL basic_throughput: 16 pixels spanned %0d cycles, expected 16", last_hs - first_hs + 1);
    else passes++;
  endtask

  task automatic test_backpressure();
    sel = 0;
    push_model(0);
    run_frame(1, -1, 0, 8'h00);
    check_latency("stall");
  endtask

  task automatic test_base_wrap();
    logic [7:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    sel = 1;
    push_model(1);
    run_frame(0, -1, 0, 8'hFE);
    checks++;
    if (addr_q.size() != 4)
      $display("FAIL wrap_addr_count: %0d addresses, expected 4", addr_q.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      if (i < addr_q.size()) begin
        checks++;
        if (addr_q[i] !== ea[i])
          $display("FAIL wrap_addr %0d: rd_addr=%h, expected %h", i, addr_q[i], ea[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    push_model(0);
    run_frame(0, 5, 1, 8'h00);
    push_model(0);
    run_frame(0, -1, 0, 8'h00);
    check_latency("restart");
  endtask

  task automatic test_reset_mid_frame();
    sel = 0;
    push_model(0);
    run_frame(0, 5, 2, 8'h00);
    push_model(0);
    run_frame(0, -1, 0, 8'h00);
    check_latency("post_reset");
  endtask

  task automatic test_one_pixel_per_word();
    sel = 2;
    push_model(2);
    run_frame(0, -1, 0, 8'h00);
    check_latency("ppw1");
    checks++;
    if (last_hs - first_hs != 7)
      $display("FAIL ppw1_throughput: 8 pixels spanned %0d cycles, expected 8", last_hs - first_hs + 1);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00; mem_b[i] = 8'h00; mem_c[i] = 8'h00;
    end
    mem_a[0] = 8'hE4; mem_a[1] = 8'h1B; mem_a[2] = 8'hFF; mem_a[3] = 8'h00;
    mem_b[254] = 8'hA5; mem_b[255] = 8'h3C; mem_b[0] = 8'h96; mem_b[1] = 8'h0F;
    for (int i = 0; i < 8; i++) mem_c[i] = 8'(8'h11 * (i + 1));
    test_reset();
    test_basic();
    test_backpressure();
    test_base_wrap();
    test_back_to_back();
    test_reset_mid_frame();
    test_one_pixel_per_word();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
